// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between a set of requesters and the round-robin arbiter.
// The master side drives requests and releases; the slave side returns the grant.
interface rr_onehot_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;
  logic          timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, release on done/request drop,
// and a hold timer that revokes a grant after MAX_HOLD consecutive cycles.
module rr_onehot_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst,
  rr_onehot_arbiter_if.slave arb
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gntValid_q, gntValid_d;
  logic [IW-1:0] gntId_q, gntId_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  logic          ownerReq;
  logic          timerHit;
  logic          releaseNow;
  logic [IW-1:0] nextPtr;
  logic [N-1:0]  maskedReq;
  logic [IW:0]   idlePick;
  logic [IW:0]   relPick;

  // Returns {found, index} of the first set bit scanning upward from p with wraparound.
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic          found;
    logic [IW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      logic [IW-1:0] k;
      k = IW'((int'(p) + i) % N);
      if (!found && r[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    return {found, idx};
  endfunction

  assign ownerReq   = arb.req[gntId_q];
  assign timerHit   = (hold_q == HOLD_LAST);
  assign releaseNow = arb.done | ~ownerReq | timerHit;
  assign nextPtr    = (gntId_q == LAST_ID) ? '0 : gntId_q + IW'(1);
  // The grant register is one-hot on the owner, so it doubles as the release mask.
  assign maskedReq  = arb.req & ~gnt_q;
  assign idlePick   = pick(arb.req, ptr_q);
  assign relPick    = pick(maskedReq, nextPtr);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gntValid_d = gntValid_q;
    gntId_d    = gntId_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (idlePick[IW]) begin
          state_d             = GRANT;
          gnt_d               = '0;
          gnt_d[idlePick[IW-1:0]] = 1'b1;
          gntValid_d          = 1'b1;
          gntId_d             = idlePick[IW-1:0];
          hold_d              = '0;
        end
      end
      GRANT: begin
        if (releaseNow) begin
          ptr_d     = nextPtr;
          timeout_d = timerHit & ~arb.done & ownerReq;
          hold_d    = '0;
          gnt_d     = '0;
          if (relPick[IW]) begin
            gnt_d[relPick[IW-1:0]] = 1'b1;
            gntValid_d             = 1'b1;
            gntId_d                = relPick[IW-1:0];
          end else begin
            state_d    = IDLE;
            gntValid_d = 1'b0;
            gntId_d    = '0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        gntValid_d = 1'b0;
        gntId_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gntValid_q <= 1'b0;
      gntId_q    <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gntValid_q <= gntValid_d;
      gntId_q    <= gntId_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.gnt_valid = gntValid_q;
  assign arb.gnt_id    = gntId_q;
  assign arb.timeout   = timeout_q;
endmodule
